// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_pkg
//  Purpose  : Shared types and default constants for the mouse input
//             conditioner (mouse_click_ctl and mouse_btn_fsm).
//  Contents : btn_state_t       - per-button FSM state
//             DEF_DEBOUNCE      - default press debounce length (cycles)
//             DEF_HOLD_CYCLES   - default long-press threshold (cycles)
//             DEF_MAX_X/MAX_Y   - default clamp bounds (800x600 screen)
//  Revision : 1.0 - initial release
// ============================================================================
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE    = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 65_000_000;
  localparam int unsigned DEF_MAX_X       = 799;
  localparam int unsigned DEF_MAX_Y       = 599;

endpackage : mouse_pkg
`default_nettype wire

// File: rtl/mouse_btn_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_btn_fsm
//  Purpose  : Single-button debounce / click / long-press FSM with a
//             saturating cycle counter.
//  Ports    : clk          in   system clock
//             rst          in   synchronous active-high reset
//             i_btn_q      in   registered raw button level
//             o_level      out  debounced level (PRESSED or HELD)
//             o_click      out  1-cycle pulse on release of a short press
//             o_hold       out  1-cycle pulse when the press becomes long
//             o_click_nxt  out  combinational: o_click asserts at next edge
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_btn_fsm
  import mouse_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_q,
  output logic o_level,
  output logic o_click,
  output logic o_hold,
  output logic o_click_nxt
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_click;
  logic             r_hold;
  logic [CNT_W-1:0] w_cnt_inc;

  // Counter never wraps, even if the thresholds are misconfigured.
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  // Release is undebounced: the click is decided by the very next edge,
  // which lets the top capture the click position on that same edge.
  assign o_click_nxt = (r_state == PRESSED) && !i_btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_click <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_click <= 1'b0;
      r_hold  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_btn_q) begin
            r_state <= ARMING;
            r_cnt   <= c_CNT_ONE;
          end
        end
        ARMING: begin
          if (!i_btn_q) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PRESSED: begin
          // Release takes priority over reaching the hold threshold.
          if (!i_btn_q) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_click <= 1'b1;
          end else if (r_cnt == c_HOLD_LAST) begin
            r_state <= HELD;
            r_hold  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          // Counter is frozen here; only a release leaves this state.
          if (!i_btn_q) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_click = r_click;
  assign o_hold  = r_hold;

endmodule : mouse_btn_fsm
`default_nettype wire

// File: rtl/mouse_click_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_click_ctl
//  Purpose  : Mouse input conditioner between the mouse decoder and the
//             game/UI logic. Registers position and buttons, debounces each
//             button, emits click/hold pulses and latches the click position.
//  Config   : MOUSE_CLAMP_EN - when defined, registered positions are
//             clamped to MAX_X / MAX_Y (unsigned); otherwise pass-through.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             xpos, ypos   in  POS_W   raw cursor position
//             btn          in  N_BTN   raw buttons (bit0 left, bit1 right)
//             xposout/yposout  POS_W   registered (optionally clamped) pos
//             btn_level    out N_BTN   debounced levels
//             click        out N_BTN   1-cycle pulse, short press released
//             hold         out N_BTN   1-cycle pulse, long press detected
//             click_xpos/click_ypos    position at the most recent click
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_click_ctl
  import mouse_pkg::*;
#(
  parameter int unsigned POS_W       = 12,
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned MAX_X       = DEF_MAX_X,
  parameter int unsigned MAX_Y       = DEF_MAX_Y
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  input  logic [N_BTN-1:0] btn,
  output logic [POS_W-1:0] xposout,
  output logic [POS_W-1:0] yposout,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] click,
  output logic [N_BTN-1:0] hold,
  output logic [POS_W-1:0] click_xpos,
  output logic [POS_W-1:0] click_ypos
);

`ifdef MOUSE_CLAMP_EN
  localparam bit c_CLAMP_EN = 1'b1;
`else
  localparam bit c_CLAMP_EN = 1'b0;
`endif

  logic [POS_W-1:0] r_xpos;
  logic [POS_W-1:0] r_ypos;
  logic [N_BTN-1:0] r_btn_q;
  logic [POS_W-1:0] r_click_x;
  logic [POS_W-1:0] r_click_y;

  logic [POS_W-1:0] w_x_clamped;
  logic [POS_W-1:0] w_y_clamped;
  logic [POS_W-1:0] w_x_stage;
  logic [POS_W-1:0] w_y_stage;
  logic [N_BTN-1:0] w_click_nxt;

  // Compare in 32 bits so bounds wider than the bus never truncate.
  assign w_x_clamped = (32'(xpos) > MAX_X) ? POS_W'(MAX_X) : xpos;
  assign w_y_clamped = (32'(ypos) > MAX_Y) ? POS_W'(MAX_Y) : ypos;
  assign w_x_stage   = c_CLAMP_EN ? w_x_clamped : xpos;
  assign w_y_stage   = c_CLAMP_EN ? w_y_clamped : ypos;

  // Stage 1: position and raw button register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos  <= '0;
      r_ypos  <= '0;
      r_btn_q <= '0;
    end else begin
      r_xpos  <= w_x_stage;
      r_ypos  <= w_y_stage;
      r_btn_q <= btn;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      mouse_btn_fsm #(
        .DEBOUNCE    (DEBOUNCE),
        .HOLD_CYCLES (HOLD_CYCLES)
      ) u_btn_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_btn_q     (r_btn_q[gi]),
        .o_level     (btn_level[gi]),
        .o_click     (click[gi]),
        .o_hold      (hold[gi]),
        .o_click_nxt (w_click_nxt[gi])
      );
    end
  endgenerate

  // Capture on the edge that raises any click bit; one shared position
  // serves simultaneous clicks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_click_x <= '0;
      r_click_y <= '0;
    end else if (|w_click_nxt) begin
      r_click_x <= r_xpos;
      r_click_y <= r_ypos;
    end
  end

  assign xposout    = r_xpos;
  assign yposout    = r_ypos;
  assign click_xpos = r_click_x;
  assign click_ypos = r_click_y;

endmodule : mouse_click_ctl
`default_nettype wire

// File: tb/tb_mouse_click_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mouse_click_ctl
//  Purpose  : Self-checking bench for mouse_click_ctl. A run-length model of
//             each button (consecutive sampled-high cycles) predicts level,
//             click and hold; positions are predicted with a plain min().
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_click_ctl;

  localparam int POS_W = 12;
  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 20;
  localparam int MX    = 799;
  localparam int MY    = 599;

`ifdef MOUSE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [POS_W-1:0] xpos, ypos;
  logic [N_BTN-1:0] btn;
  logic [POS_W-1:0] xposout, yposout, click_xpos, click_ypos;
  logic [N_BTN-1:0] btn_level, click, hold;

  always #5 clk = ~clk;

  mouse_click_ctl #(
    .POS_W(POS_W), .N_BTN(N_BTN), .DEBOUNCE(DEB), .HOLD_CYCLES(HOLD),
    .MAX_X(MX), .MAX_Y(MY)
  ) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .btn(btn),
    .xposout(xposout), .yposout(yposout), .btn_level(btn_level),
    .click(click), .hold(hold), .click_xpos(click_xpos), .click_ypos(click_ypos)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [N_BTN-1:0] m_q;
  int               m_run [N_BTN];
  logic [POS_W-1:0] e_x, e_y, e_cx, e_cy;
  logic [N_BTN-1:0] e_lvl, e_click, e_hold;

  // Observed pulse counters for directed scenarios
  int n_click0, n_hold0, n_click1, n_lvl1;

  function automatic logic [POS_W-1:0] clampv(logic [POS_W-1:0] v, int mx);
    return (CLAMP && int'(v) > mx) ? POS_W'(mx) : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then compare every output just after the edge.
  task automatic step();
    if (rst) begin
      m_q = '0;
      for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
      e_x = '0; e_y = '0; e_cx = '0; e_cy = '0;
      e_lvl = '0; e_click = '0; e_hold = '0;
    end else begin
      e_click = '0;
      e_hold  = '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (m_q[i]) begin
          if (m_run[i] < 1_000_000) m_run[i]++;
          e_lvl[i]  = (m_run[i] >= DEB);
          e_hold[i] = (m_run[i] == DEB + HOLD);
        end else begin
          e_click[i] = (m_run[i] >= DEB) && (m_run[i] < DEB + HOLD);
          m_run[i]   = 0;
          e_lvl[i]   = 1'b0;
        end
      end
      if (|e_click) begin
        e_cx = e_x;
        e_cy = e_y;
      end
      e_x = clampv(xpos, MX);
      e_y = clampv(ypos, MY);
      m_q = btn;
    end
    @(posedge clk);
    #1;
    chk("xposout",    32'(xposout),    32'(e_x));
    chk("yposout",    32'(yposout),    32'(e_y));
    chk("btn_level",  32'(btn_level),  32'(e_lvl));
    chk("click",      32'(click),      32'(e_click));
    chk("hold",       32'(hold),       32'(e_hold));
    chk("click_xpos", 32'(click_xpos), 32'(e_cx));
    chk("click_ypos", 32'(click_ypos), 32'(e_cy));
    n_click0 += int'(click[0]);
    n_click1 += int'(click[1]);
    n_hold0  += int'(hold[0]);
    n_lvl1   += int'(btn_level[1]);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_counts();
    n_click0 = 0; n_click1 = 0; n_hold0 = 0; n_lvl1 = 0;
  endtask

  int seg [N_BTN];

  initial begin
    clr_counts();
    rst = 1'b1; btn = 2'b11; xpos = 12'd100; ypos = 12'd50;
    @(negedge clk);

    // Reset with buttons held: everything reads 0.
    run(3);
    chk("rst_all_zero", 32'({xposout, yposout, btn_level, click, hold, click_xpos, click_ypos}), 32'd0);

    // Buttons still held after reset must re-arm; level rises DEBOUNCE
    // cycles after the first non-reset sampling edge.
    rst = 1'b0;
    run(4);
    chk("lvl_before_deb", 32'(btn_level[0]), 32'd0);
    run(1);
    chk("lvl_after_deb", 32'(btn_level[0]), 32'd1);
    btn = 2'b00;
    run(4);

    // Short click at (300,200).
    clr_counts();
    xpos = 12'd300; ypos = 12'd200;
    btn = 2'b01;
    run(10);
    chk("short_lvl", 32'(btn_level[0]), 32'd1);
    btn = 2'b00;
    run(4);
    chk("short_nclick", 32'(n_click0), 32'd1);
    chk("short_nhold",  32'(n_hold0),  32'd0);
    chk("short_cx",     32'(click_xpos), 32'd300);
    chk("short_cy",     32'(click_ypos), 32'd200);

    // Glitch on the right button.
    clr_counts();
    xpos = 12'd10; ypos = 12'd20;
    btn = 2'b10;
    run(2);
    btn = 2'b00;
    run(6);
    chk("glitch_lvl",   32'(n_lvl1),   32'd0);
    chk("glitch_click", 32'(n_click1), 32'd0);

    // Long press: one hold, no click.
    clr_counts();
    btn = 2'b01;
    run(40);
    btn = 2'b00;
    run(4);
    chk("long_nhold",  32'(n_hold0),  32'd1);
    chk("long_nclick", 32'(n_click0), 32'd0);

    // Race: release lands exactly when the counter reaches HOLD-1.
    clr_counts();
    xpos = 12'd444; ypos = 12'd333;
    btn = 2'b01;
    run(DEB + HOLD - 1);
    btn = 2'b00;
    run(4);
    chk("race_nclick", 32'(n_click0), 32'd1);
    chk("race_nhold",  32'(n_hold0),  32'd0);

    // Clamp / pass-through of out-of-range positions.
    xpos = 12'd1023; ypos = 12'd700;
    run(1);
    chk("clamp_x", 32'(xposout), CLAMP ? 32'd799 : 32'd1023);
    chk("clamp_y", 32'(yposout), CLAMP ? 32'd599 : 32'd700);

    // Randomised segments: glitches, short presses, races and long holds,
    // with occasional resets mid-press.
    for (int i = 0; i < N_BTN; i++) seg[i] = 1;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N_BTN; i++) begin
        seg[i]--;
        if (seg[i] <= 0) begin
          btn[i] = ~btn[i];
          seg[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 32));
        end
      end
      rst  = ($urandom_range(0, 249) == 0);
      xpos = POS_W'($urandom);
      ypos = POS_W'($urandom);
      step();
    end
    rst = 1'b0;
    btn = 2'b00;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mouse_click_ctl
`default_nettype wire

// File: doc/mouse_click_ctl.md
# mouse_click_ctl

Parametrised mouse input conditioner that sits between the mouse decoder and the game/UI logic, replacing the plain register stage. It registers cursor position and raw buttons, debounces each of N_BTN buttons, and produces per-button debounced levels, single-cycle click and hold pulses, and a latched click position. Optionally, it clamps the cursor to the visible screen area.

## Interface
- POS_W, 12: width of the position buses.
- N_BTN, 2: button channel count; bit 0 = left, bit 1 = right.
- DEBOUNCE, 4: cycles a press must be stable before it is accepted; legal range ≥2.
- HOLD_CYCLES, 65_000_000: cycles in PRESSED before a long-press (hold) is declared; legal range > DEBOUNCE.
- MAX_X, 799: highest legal x (clamp bound).
- MAX_Y, 599: highest legal y (clamp bound).

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- xpos  in  POS_W  raw cursor x.
- ypos  in  POS_W  raw cursor y.
- btn  in  N_BTN  raw button levels.
- xposout  out  POS_W  registered, optionally clamped x.
- yposout  out  POS_W  registered, optionally clamped y.
- btn_level  out  N_BTN  debounced button levels.
- click  out  N_BTN  1-cycle pulse on release of a short press.
- hold  out  N_BTN  1-cycle pulse when a press becomes a long press.
- click_xpos  out  POS_W  xposout value captured at the most recent click.
- click_ypos  out  POS_W  yposout value captured at the most recent click.

## Operation
- Stage 1 registers xpos, ypos and btn into btn_q and the position registers; xposout and yposout are these position registers.
- There is one FSM per button, driven by btn_q[i], with a counter cnt of width $clog2(HOLD_CYCLES+1).
  - IDLE:
    - btn_q=1 → ARMING, cnt=1.
  - ARMING:
    - btn_q=0 → IDLE; no outputs.
    - btn_q=1 and cnt==DEBOUNCE-1 → PRESSED, cnt=0.
    - Otherwise cnt+1.
  - PRESSED:
    - btn_q=0 → IDLE; click[i] pulses.
    - cnt==HOLD_CYCLES-1 → HELD; hold[i] pulses.
    - Otherwise cnt+1.
  - HELD:
    - btn_q=0 → IDLE; no click.
- btn_level[i] = 1 in the PRESSED and HELD states; it is registered.
- Release is not debounced: any 0 on btn_q ends the press.
- Simultaneous release and hold threshold in PRESSED: release wins. click pulses; hold does not.
- click_xpos and click_ypos load the current xposout and yposout at the same edge that asserts any click bit. They hold their value otherwise.
- Simultaneous clicks on several buttons: all click bits assert; one shared position is captured.
- The counter saturates and never wraps; cnt does not advance in HELD.

## Timing
- Reset values: all outputs are 0, and every FSM is in IDLE with cnt=0.
- Reset mid-press: the FSM returns to IDLE with no click or hold pulse. A button still held after reset must re-arm through ARMING.
- Position latency: 1 cycle from input to xposout and yposout.
- Press latency: raw btn sampled high at edge t and stable → btn_level high after edge t+DEBOUNCE.
- Click latency: raw btn sampled low at edge r → click high during the cycle after edge r+1, for exactly 1 cycle.
- Hold latency: hold pulses HOLD_CYCLES cycles after btn_level rises.
- Glitch handling: a press shorter than DEBOUNCE sampled cycles produces no btn_level, click or hold.

## Configuration
- MOUSE_CLAMP_EN defined:
  - Stage 1 stores min(xpos, MAX_X) and min(ypos, MAX_Y), both unsigned.
  - click_xpos and click_ypos inherit the clamped values.
- MOUSE_CLAMP_EN undefined: positions pass through unmodified.
- Button behaviour is identical in both cases.

## Structure
- mouse_pkg holds:
  - the btn_state_t enum {IDLE, ARMING, PRESSED, HELD};
  - default constants for DEBOUNCE, HOLD_CYCLES, MAX_X and MAX_Y.
- Sub-module mouse_btn_fsm: a single-button FSM plus counter, producing level, click and hold. It is instantiated N_BTN times in a generate loop.
- The top level owns stage 1, the clamp logic and the click-position capture.

## Test plan
All scenarios use DEBOUNCE=4, HOLD_CYCLES=20, MAX_X=799, MAX_Y=599.
- Reset check: assert rst with btn=2'b11 and xpos=100 → all outputs 0. After deassert, btn_level[0] rises 4 cycles later.
- Short click: xpos=300, ypos=200, btn[0] high for 10 cycles → btn_level[0] high, then one click[0] pulse, click_xpos=300, click_ypos=200, and no hold.
- Glitch rejection: btn[1] high for 2 cycles → no btn_level[1], no click[1], no hold[1].
- Long press: btn[0] high for 40 cycles → hold[0] pulses once, 20 cycles after btn_level[0] rises. Release gives no click.
- Race: release lands on the cycle cnt reaches 19 → click[0] pulses and hold[0] stays 0.
- Clamp, MOUSE_CLAMP_EN defined: xpos=1023, ypos=700 → xposout=799, yposout=599. With the macro undefined → xposout=1023, yposout=700.
